// File: rtl/decode_exec_pkg.sv
// Shared types for decode_exec_unit: instruction type and opcode enums,
// ALU operation enum and the datapath width.
package decode_exec_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {TYPE_R = 2'b00, TYPE_M = 2'b01, TYPE_B = 2'b10, TYPE_S = 2'b11} itype_e;

   typedef enum logic [2:0] {
      R_AND = 3'd0, R_OR = 3'd1, R_XOR = 3'd2, R_ADD = 3'd3,
      R_SUB = 3'd4, R_SLT = 3'd5, R_SLTE = 3'd6, R_SEQ = 3'd7
   } rop_e;

   typedef enum logic [2:0] {
      M_SB = 3'd0, M_LB = 3'd1, M_LL = 3'd2, M_LL2 = 3'd3,
      M_LIL = 3'd4, M_LIU = 3'd5, M_LLR = 3'd6, M_NOP = 3'd7
   } mop_e;

   typedef enum logic [1:0] {B_BEQ = 2'd0, B_BLT = 2'd1, B_BLTE = 2'd2, B_BUN = 2'd3} bop_e;

   typedef enum logic [1:0] {S_LSL = 2'd0, S_LSR = 2'd1, S_LSI = 2'd2, S_RSI = 2'd3} sop_e;

   typedef enum logic [3:0] {
      ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_SLTE, ALU_SEQ, ALU_SHL, ALU_SHR, ALU_ZERO
   } alu_op_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: logic, modulo-256 arithmetic, unsigned compare and
// zero-fill logical shifts (amounts of 8 or more give zero).
module exec_alu
   import decode_exec_pkg::*;
(
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              equal,
   output logic              less_than
);

   logic big_shift;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      equal     = (a == b);
      less_than = (a < b);
      big_shift = |b[DATA_W-1:3];
      result    = '0;
      case (op)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLT:  result = {{(DATA_W-1){1'b0}}, less_than};
         ALU_SLTE: result = {{(DATA_W-1){1'b0}}, less_than | equal};
         ALU_SEQ:  result = {{(DATA_W-1){1'b0}}, equal};
         ALU_SHL:  result = big_shift ? '0 : (a << b[2:0]);
         ALU_SHR:  result = big_shift ? '0 : (a >> b[2:0]);
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/decode_exec_unit.sv
// Combinational instruction decode around exec_alu, plus the LUT holding
// register and compare flags. Define LUT_IMM_EN to implement LIL/LIU.
module decode_exec_unit
   import decode_exec_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [8:0]        instr,
   input  logic [DATA_W-1:0] rdata_a,
   input  logic [DATA_W-1:0] rdata_b,
   input  logic [DATA_W-1:0] lut_value,
   output logic [1:0]        r_addr1,
   output logic [1:0]        r_addr2,
   output logic              reg_to_reg,
   output logic              mem_to_reg,
   output logic              reg_to_mem,
   output logic              lut_to_reg,
   output logic [DATA_W-1:0] lut_index,
   output logic [1:0]        lut_reg_dst,
   output logic              branch_en,
   output logic [DATA_W-1:0] branch_index,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] lut_reg,
   output logic              equal,
   output logic              less_than
);

   itype_e            itype;
   alu_op_e           alu_op;
   logic [DATA_W-1:0] operand2;
   logic              cmp_en;
   logic              load_lut;
   logic [DATA_W-1:0] lut_next;
   logic              alu_eq;
   logic              alu_lt;

   assign itype = itype_e'(instr[8:7]);

   always_comb begin
      r_addr1      = '0;
      r_addr2      = '0;
      reg_to_reg   = 1'b0;
      mem_to_reg   = 1'b0;
      reg_to_mem   = 1'b0;
      lut_to_reg   = 1'b0;
      lut_index    = '0;
      lut_reg_dst  = '0;
      branch_en    = 1'b0;
      branch_index = '0;
      alu_op       = ALU_ZERO;
      operand2     = rdata_b;
      cmp_en       = 1'b0;
      load_lut     = 1'b0;
      lut_next     = lut_reg;
      case (itype)
         TYPE_R: begin
            r_addr1    = instr[3:2];
            r_addr2    = instr[1:0];
            reg_to_reg = 1'b1;
            case (rop_e'(instr[6:4]))
               R_AND:  alu_op = ALU_AND;
               R_OR:   alu_op = ALU_OR;
               R_XOR:  alu_op = ALU_XOR;
               R_ADD:  alu_op = ALU_ADD;
               R_SUB:  alu_op = ALU_SUB;
               R_SLT:  begin alu_op = ALU_SLT;  cmp_en = 1'b1; end
               R_SLTE: begin alu_op = ALU_SLTE; cmp_en = 1'b1; end
               default: begin alu_op = ALU_SEQ; cmp_en = 1'b1; end
            endcase
         end
         TYPE_M: begin
            case (mop_e'(instr[6:4]))
               M_SB: begin
                  r_addr1    = instr[3:2];
                  r_addr2    = instr[1:0];
                  reg_to_mem = 1'b1;
               end
               M_LB: begin
                  r_addr1    = instr[3:2];
                  r_addr2    = instr[1:0];
                  mem_to_reg = 1'b1;
               end
               M_LL: begin
                  lut_index = {4'h0, instr[3:0]};
                  load_lut  = 1'b1;
                  lut_next  = lut_value;
               end
               M_LL2: begin
                  lut_index = {4'h1, instr[3:0]};
                  load_lut  = 1'b1;
                  lut_next  = lut_value;
               end
`ifdef LUT_IMM_EN
               M_LIL: begin
                  load_lut = 1'b1;
                  lut_next = {lut_reg[7:4], instr[3:0]};
               end
               M_LIU: begin
                  load_lut = 1'b1;
                  lut_next = {instr[3:0], lut_reg[3:0]};
               end
`endif
               M_LLR: begin
                  lut_to_reg  = 1'b1;
                  lut_reg_dst = instr[3:2];
               end
               default: ;
            endcase
         end
         TYPE_B: begin
            // Branches read the registered flags, i.e. the last compare's outcome.
            branch_index = {3'b000, instr[4:0]};
            case (bop_e'(instr[6:5]))
               B_BEQ:   branch_en = equal;
               B_BLT:   branch_en = less_than;
               B_BLTE:  branch_en = less_than | equal;
               default: branch_en = 1'b1;
            endcase
         end
         default: begin
            r_addr1    = instr[4:3];
            reg_to_reg = 1'b1;
            case (sop_e'(instr[6:5]))
               S_LSL: begin r_addr2 = instr[2:1]; alu_op = ALU_SHL; end
               S_LSR: begin r_addr2 = instr[2:1]; alu_op = ALU_SHR; end
               S_LSI: begin operand2 = {5'b00000, instr[2:0]}; alu_op = ALU_SHL; end
               default: begin operand2 = {5'b00000, instr[2:0]}; alu_op = ALU_SHR; end
            endcase
         end
      endcase
   end

   exec_alu u_alu (
      .op        (alu_op),
      .a         (rdata_a),
      .b         (operand2),
      .result    (alu_result),
      .equal     (alu_eq),
      .less_than (alu_lt)
   );

   // NOTE: state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         lut_reg   <= '0;
         equal     <= 1'b0;
         less_than <= 1'b0;
      end else begin
         if (load_lut) lut_reg <= lut_next;
         if (cmp_en) begin
            equal     <= alu_eq;
            less_than <= alu_lt;
         end
      end
   end

endmodule

// File: tb/tb_decode_exec_unit.sv
// Self-checking bench for decode_exec_unit: directed scenarios followed by
// random instructions, all compared against an arithmetic reference model.
module tb_decode_exec_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] instr;
   logic [7:0] rdata_a, rdata_b, lut_value;
   logic [1:0] r_addr1, r_addr2;
   logic       reg_to_reg, mem_to_reg, reg_to_mem, lut_to_reg;
   logic [7:0] lut_index;
   logic [1:0] lut_reg_dst;
   logic       branch_en;
   logic [7:0] branch_index, alu_result, lut_reg;
   logic       equal, less_than;

   int checks = 0;
   int errors = 0;
   int m_lut  = 0;
   int m_eq   = 0;
   int m_lt   = 0;

   always #5 clk = ~clk;

   decode_exec_unit dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .rdata_a      (rdata_a),
      .rdata_b      (rdata_b),
      .lut_value    (lut_value),
      .r_addr1      (r_addr1),
      .r_addr2      (r_addr2),
      .reg_to_reg   (reg_to_reg),
      .mem_to_reg   (mem_to_reg),
      .reg_to_mem   (reg_to_mem),
      .lut_to_reg   (lut_to_reg),
      .lut_index    (lut_index),
      .lut_reg_dst  (lut_reg_dst),
      .branch_en    (branch_en),
      .branch_index (branch_index),
      .alu_result   (alu_result),
      .lut_reg      (lut_reg),
      .equal        (equal),
      .less_than    (less_than)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one instruction, check the decode outputs, clock it, check state.
   task automatic step(input string lbl, input logic [8:0] i, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] lv, input logic rst);
      int ty, op, av, bv, amt, lo;
      int e_r1, e_r2, e_rr, e_mr, e_rm, e_lr, e_li, e_dst, e_br, e_bi, e_res;
      int n_lut, n_eq, n_lt;
      instr = i; rdata_a = a; rdata_b = b; lut_value = lv; reset = rst;
      ty = int'(i[8:7]); av = int'(a); bv = int'(b); lo = int'(i[3:0]);
      e_r1 = 0; e_r2 = 0; e_rr = 0; e_mr = 0; e_rm = 0; e_lr = 0;
      e_li = 0; e_dst = 0; e_br = 0; e_bi = 0; e_res = 0;
      n_lut = m_lut; n_eq = m_eq; n_lt = m_lt;
      case (ty)
         0: begin
            op = int'(i[6:4]); e_r1 = int'(i[3:2]); e_r2 = int'(i[1:0]); e_rr = 1;
            case (op)
               0: e_res = av & bv;
               1: e_res = av | bv;
               2: e_res = av ^ bv;
               3: e_res = (av + bv) % 256;
               4: e_res = (av - bv + 256) % 256;
               5: e_res = (av < bv) ? 1 : 0;
               6: e_res = (av <= bv) ? 1 : 0;
               default: e_res = (av == bv) ? 1 : 0;
            endcase
            if (op >= 5) begin
               n_eq = (av == bv) ? 1 : 0;
               n_lt = (av < bv) ? 1 : 0;
            end
         end
         1: begin
            op = int'(i[6:4]);
            if (op == 0) begin e_r1 = int'(i[3:2]); e_r2 = int'(i[1:0]); e_rm = 1; end
            if (op == 1) begin e_r1 = int'(i[3:2]); e_r2 = int'(i[1:0]); e_mr = 1; end
            if (op == 2) begin e_li = lo;      n_lut = int'(lv); end
            if (op == 3) begin e_li = 16 + lo; n_lut = int'(lv); end
`ifdef LUT_IMM_EN
            if (op == 4) n_lut = (m_lut & 8'hF0) | lo;
            if (op == 5) n_lut = (m_lut & 8'h0F) | (lo * 16);
`endif
            if (op == 6) begin e_lr = 1; e_dst = int'(i[3:2]); end
         end
         2: begin
            op = int'(i[6:5]); e_bi = int'(i[4:0]);
            case (op)
               0: e_br = m_eq;
               1: e_br = m_lt;
               2: e_br = m_eq | m_lt;
               default: e_br = 1;
            endcase
         end
         default: begin
            op = int'(i[6:5]); e_r1 = int'(i[4:3]); e_rr = 1;
            if (op < 2) begin e_r2 = int'(i[2:1]); amt = bv; end
            else amt = int'(i[2:0]);
            if (amt >= 8) e_res = 0;
            else if (op % 2 == 0) e_res = (av * (1 << amt)) % 256;
            else e_res = av / (1 << amt);
         end
      endcase
      if (rst) begin n_lut = 0; n_eq = 0; n_lt = 0; end
      #1;
      check({lbl, ".r_addr1"},      32'(r_addr1),      e_r1);
      check({lbl, ".r_addr2"},      32'(r_addr2),      e_r2);
      check({lbl, ".reg_to_reg"},   32'(reg_to_reg),   e_rr);
      check({lbl, ".mem_to_reg"},   32'(mem_to_reg),   e_mr);
      check({lbl, ".reg_to_mem"},   32'(reg_to_mem),   e_rm);
      check({lbl, ".lut_to_reg"},   32'(lut_to_reg),   e_lr);
      check({lbl, ".lut_index"},    32'(lut_index),    e_li);
      check({lbl, ".lut_reg_dst"},  32'(lut_reg_dst),  e_dst);
      check({lbl, ".branch_en"},    32'(branch_en),    e_br);
      check({lbl, ".branch_index"}, 32'(branch_index), e_bi);
      check({lbl, ".alu_result"},   32'(alu_result),   e_res);
      @(posedge clk);
      #1;
      m_lut = n_lut; m_eq = n_eq; m_lt = n_lt;
      check({lbl, ".lut_reg"},   32'(lut_reg),   m_lut);
      check({lbl, ".equal"},     32'(equal),     m_eq);
      check({lbl, ".less_than"}, 32'(less_than), m_lt);
   endtask

   initial begin
      step("reset", 9'b00_000_00_00, 8'h12, 8'h34, 8'h00, 1'b1);
      check("reset.lut_zero", 32'(lut_reg), 32'h00);

      step("add", 9'b00_011_01_10, 8'h7F, 8'h81, 8'h00, 1'b0);
      check("add.result", 32'(alu_result), 32'h00);
      check("add.addr1",  32'(r_addr1),    32'd1);
      check("add.addr2",  32'(r_addr2),    32'd2);

      step("slt", 9'b00_101_00_01, 8'h03, 8'h05, 8'h00, 1'b0);
      check("slt.result", 32'(alu_result), 32'h01);
      check("slt.lt",     32'(less_than),  32'd1);
      check("slt.eq",     32'(equal),      32'd0);
      step("blt", 9'b10_01_00101, 8'h00, 8'h00, 8'h00, 1'b0);
      check("blt.taken", 32'(branch_en),    32'd1);
      check("blt.index", 32'(branch_index), 32'd5);
      step("beq", 9'b10_00_00101, 8'h00, 8'h00, 8'h00, 1'b0);
      check("beq.taken", 32'(branch_en), 32'd0);

`ifdef LUT_IMM_EN
      step("liu", 9'b01_101_1010, 8'h00, 8'h00, 8'h00, 1'b0);
      step("lil", 9'b01_100_0101, 8'h00, 8'h00, 8'h00, 1'b0);
      check("lui.lut", 32'(lut_reg), 32'hA5);
`else
      step("ll0", 9'b01_010_0000, 8'h00, 8'h00, 8'h66, 1'b0);
      step("liu", 9'b01_101_1010, 8'h00, 8'h00, 8'h00, 1'b0);
      step("lil", 9'b01_100_0101, 8'h00, 8'h00, 8'h00, 1'b0);
      check("lui.lut_kept", 32'(lut_reg), 32'h66);
`endif
      step("llr", 9'b01_110_10_00, 8'h00, 8'h00, 8'h00, 1'b0);
      check("llr.en",  32'(lut_to_reg),  32'd1);
      check("llr.dst", 32'(lut_reg_dst), 32'd2);

      step("ll2", 9'b01_011_0011, 8'h00, 8'h00, 8'h3C, 1'b0);
      check("ll2.index", 32'(lut_index), 32'h13);
      check("ll2.lut",   32'(lut_reg),   32'h3C);

      step("rsi", 9'b11_11_00_111, 8'h80, 8'h00, 8'h00, 1'b0);
      check("rsi.result", 32'(alu_result), 32'h01);
      step("lsl", 9'b11_00_00_01_0, 8'hFF, 8'h09, 8'h00, 1'b0);
      check("lsl.result", 32'(alu_result), 32'h00);

      step("seq", 9'b00_111_00_01, 8'h55, 8'h55, 8'h00, 1'b0);
      step("ll",  9'b01_010_0101, 8'h00, 8'h00, 8'hA5, 1'b0);
      check("pre.eq",  32'(equal),   32'd1);
      check("pre.lut", 32'(lut_reg), 32'hA5);
      step("rst_mid", 9'b00_101_00_01, 8'h01, 8'h02, 8'h00, 1'b1);
      check("rst.lut", 32'(lut_reg),   32'h00);
      check("rst.eq",  32'(equal),     32'd0);
      check("rst.lt",  32'(less_than), 32'd0);
      step("rst_ll", 9'b01_010_0001, 8'h00, 8'h00, 8'h77, 1'b1);
      check("rst_ll.lut", 32'(lut_reg), 32'h00);
      step("beq_rst", 9'b10_00_00011, 8'h00, 8'h00, 8'h00, 1'b0);
      check("beq_rst.taken", 32'(branch_en), 32'd0);
      step("bun", 9'b10_11_00000, 8'h00, 8'h00, 8'h00, 1'b0);
      check("bun.taken", 32'(branch_en), 32'd1);

      for (int n = 0; n < 400; n++) begin
         step("rand", 9'($urandom), 8'($urandom), 8'($urandom_range(0, 11)),
              8'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_exec_unit.md
DECODE_EXEC_UNIT -- requirements
Module: decode_exec_unit

Interface
REQ-001 Parameters: none; all widths fixed (9-bit instruction, 8-bit data, 2-bit register addresses).
REQ-002 Timing: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr  in  9  current instruction word.
REQ-006 rdata_a / rdata_b  in  8 each  register-file read data for r_addr1 / r_addr2.
REQ-007 lut_value  in  8  external LUT data, selected by lut_index.
REQ-008 r_addr1 / r_addr2  out  2 each  register read addresses.
REQ-009 reg_to_reg, mem_to_reg, reg_to_mem, lut_to_reg  out  1 each  write-back path selects, one-hot or all zero.
REQ-010 lut_index  out  8  index into the external LUT.
REQ-011 lut_reg_dst  out  2  destination register for LLR.
REQ-012 branch_en  out  1  branch taken.
REQ-013 branch_index  out  8  branch LUT index, zero-extended.
REQ-014 alu_result  out  8  ALU result.
REQ-015 lut_reg  out  8  LUT holding register.
REQ-016 equal, less_than  out  1 each  registered compare flags.

Function
REQ-017 Decoding is combinational; type=instr[8:7].
REQ-018 R-type (00): op=instr[6:4], rd=r_addr1=instr[3:2], rs=r_addr2=instr[1:0]; reg_to_reg=1.
- Ops 000..100: AND, OR, XOR, ADD (mod 256), SUB (mod 256, a-b).
- Ops 101..111: SLT, SLTE, SEQ; result 8'h01 if the condition holds, else 8'h00.
REQ-019 SLT/SLTE/SEQ capture equal<=(a==b) and less_than<=(a<b, unsigned) on the next rising edge; no other instruction changes the flags.
REQ-020 M-type (01): op=instr[6:4].
- SB 000: r_addr1=addr, r_addr2=data, reg_to_mem=1.
- LB 001: r_addr1=destination, r_addr2=address, mem_to_reg=1.
- LL 010: lut_index={4'h0,instr[3:0]}; lut_reg<=lut_value.
- LL2 011: lut_index={4'h1,instr[3:0]}; lut_reg<=lut_value.
- LIL 100: lut_reg[3:0]<=instr[3:0]; upper nibble kept.
- LIU 101: lut_reg[7:4]<=instr[3:0]; lower nibble kept.
- LLR 110: lut_to_reg=1, lut_reg_dst=instr[3:2].
- 111: no operation.
REQ-021 B-type (10): op=instr[6:5], branch_index={3'b0,instr[4:0]}.
- BEQ: taken when equal.
- BLT: taken when less_than.
- BLTE: taken when less_than|equal.
- BUN: always taken.
- Conditions use the registered flags, so a compare followed by a branch sees the compare's result.
REQ-022 S-type (11): op=instr[6:5], rd=r_addr1=instr[4:3]; reg_to_reg=1; all shifts are logical and zero-fill.
- LSL/LSR: r_addr2=instr[2:1]; amount is rdata_b; an amount >= 8 gives 8'h00.
- LSI/RSI: amount is instr[2:0].
REQ-023 ALU input mux: operand2 is {5'b0,instr[2:0]} for LSI/RSI, otherwise rdata_b; operand1 is always rdata_a.
REQ-024 Output defaults:
- Unused addresses, lut_index, branch_index, lut_reg_dst and all enables are 0.
- alu_result is 8'h00 for M-type and B-type.
REQ-025 Only state: lut_reg, equal, less_than; all other outputs are combinational with zero latency.

Reset
REQ-026 While reset is high at a rising edge, lut_reg<=8'h00, equal<=0 and less_than<=0.
REQ-027 Reset has priority over a simultaneous compare or LUT-load instruction.

Configuration
REQ-028 With macro LUT_IMM_EN defined, LIL and LIU are implemented.
REQ-029 Without LUT_IMM_EN, LIL and LIU decode as no-operation and lut_reg is unchanged.

Structure
REQ-030 Shared package decode_exec_pkg holds:
- enums for the type codes and the R/M/B/S opcodes;
- the ALU-operation enum;
- the data-width constant.
REQ-031 One combinational sub-module, exec_alu, implements logic, arithmetic, compare and shift; the operand mux and decode live in the top.

Verification
REQ-032 ADD: instr=00_011_01_10, rdata_a=0x7F, rdata_b=0x81 -> alu_result=0x00, r_addr1=1, r_addr2=2, reg_to_reg=1.
REQ-033 SLT then branches: SLT with a=3, b=5 -> result 0x01; after the edge less_than=1, equal=0. Then BLT 10_01_00101 -> branch_en=1, branch_index=5; BEQ -> branch_en=0.
REQ-034 LUT immediates (LUT_IMM_EN defined): LIU 0xA then LIL 0x5 -> lut_reg=0xA5. Then LLR dst=2 -> lut_to_reg=1, lut_reg_dst=2.
REQ-035 LL2: LL2 idx 3 -> lut_index=0x13; with lut_value=0x3C, lut_reg=0x3C after the edge.
REQ-036 Shifts: RSI a=0x80 imm=7 -> 0x01; LSL a=0xFF, b=9 -> 0x00.
REQ-037 Reset mid-operation: reset with flags=1 and lut_reg=0xA5 -> all three zero after the edge; then BEQ not taken, BUN taken.
